poly_horner_sequencer: RTL and testbench
========================================

Name: poly_horner_sequencer

Overview:
- Evaluates a polynomial y = c0 + c1·x + … + c(N-1)·x^(N-1) over one shared, pipelined multiplier using Horner's scheme.
- Replaces the fully parallel constant-product/adder-chain evaluator where area matters more than throughput.
- Coefficients are held in a run-time-writable register file, so one instance serves several curves.
- Sits between a valid/ready sample source and sink in the same sfix17_En16 fixed-point domain.

Parameters:
- NUM_COEF, 10, number of coefficients N (legal range 2..16).
- MUL_STAGES, 2, pipeline registers inside the shared multiplier (legal range 1..4).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high; clears all state.
- clk_enable  input  1  global enable; when low, all registers hold.
- in_valid  input  1  sample available.
- in_ready  output  1  block accepts a sample.
- In1  input  17  sample x, sfix17_En16.
- out_valid  output  1  result available.
- out_ready  input  1  sink accepts result.
- Out1  output  17  result y, sfix17_En16.
- ovf  output  1  at least one saturation occurred during this evaluation; qualified by out_valid.
- coef_we  input  1  coefficient write strobe.
- coef_addr  input  4  coefficient index k.
- coef_data  input  20  coefficient ck, sfix20_En18.
- coef_err  output  1  one-cycle pulse: a write was rejected.

Behaviour:
- Reset (async, active-high): state=IDLE; all coefficient registers, acc, x register, Out1, ovf, out_valid and coef_err go to 0.
- clk_enable=0: every register holds; in_ready=0; out_valid holds its value; coef_err=0.
- in_ready = (state==IDLE) & clk_enable.
- States:
  - IDLE→INIT on in_valid & in_ready; x latched.
  - INIT: acc ← c(N-1)<<2, sign-extended to 24 bits; k ← N-2; ovf cleared. → MUL.
  - MUL: issues acc·x; holds MUL_STAGES cycles. → ACC.
  - ACC: acc ← sat24(round(prod) + (ck<<2)); if k==0 → OUT, else k ← k-1 → MUL.
  - OUT: out_valid=1; Out1 and ovf stable; → IDLE on out_ready.
- Arithmetic:
  - acc is sfix24_En20. The product is sfix41_En36.
  - Product rounding: add 2^15, arithmetic shift right 16, round half toward +inf.
  - Product and add are each saturated to 24 bits; either saturation sets ovf.
  - Output: Out1 = sat17((acc + 8) >>> 4). Saturation here also sets ovf.
- Latency: for an accept in cycle T, out_valid rises in cycle T+2+(N-1)(MUL_STAGES+1). With defaults this is T+29. Throughput is one sample per latency+1 cycles minimum.
- Coefficient writes:
  - Take effect on the clock edge.
  - Accepted only in IDLE with coef_addr<NUM_COEF.
  - Otherwise dropped and coef_err pulses the next cycle; the stored coefficient is unchanged.
  - A write in the same cycle as a sample accept is accepted; the new value is used by that evaluation.
- Simultaneous events:
  - In OUT, in_ready=0, so no sample is accepted while a result is pending.
  - The first accept after a result is possible in the IDLE cycle following the out_ready handshake.
- Reset mid-evaluation: the result is discarded, no out_valid is produced, and coefficients return to 0.

Test Plan:
- Reset check: assert reset during MUL → state IDLE, out_valid=0, Out1=0, in_ready=1 in the first cycle after release with clk_enable=1.
- Constant term: c0=131072 (0.5), all other coefficients 0, x=12345 accepted at cycle T → out_valid in cycle T+29, Out1=32768, ovf=0.
- Linear term: c1=262144 (1.0), all other coefficients 0, x=16384 (0.25) → Out1=16384; with x=-65536 (-1.0) → Out1=-65536.
- Saturation: all ck=393216 (1.5), x=65535 → Out1=65535, ovf=1. The next evaluation with all ck=0 → Out1=0, ovf=0.
- Busy write and bad address: coef_we during MUL → coef_err pulse, next evaluation unaffected. coef_addr=12 with N=10 in IDLE → coef_err pulse, no register changed.
- Backpressure and enable:
  - Hold out_ready=0 for 5 cycles → out_valid, Out1 and ovf stable throughout, in_ready=0.
  - Drop clk_enable for 3 cycles mid-MUL → latency extends by exactly 3 cycles with the same result.

Source files
------------

// File: rtl/poly_horner_sequencer.sv
// poly_horner_sequencer
// Evaluates y = c0 + c1*x + ... + c(N-1)*x^(N-1) with Horner's scheme over a
// single pipelined multiplier. Coefficients live in a run-time writable file.
// Ports:
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   clk_enable        global enable; all registers hold while low
//   in_valid/in_ready sample handshake, In1 = x (sfix17_En16)
//   out_valid/out_ready result handshake, Out1 = y (sfix17_En16)
//   ovf               a saturation occurred in this evaluation (with out_valid)
//   coef_we/coef_addr/coef_data  coefficient write port (sfix20_En18)
//   coef_err          one-cycle pulse after a rejected coefficient write
module poly_horner_sequencer #(
  parameter int unsigned NUM_COEF   = 10,
  parameter int unsigned MUL_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_enable,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [16:0] In1,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [16:0] Out1,
  output logic        ovf,
  input  logic        coef_we,
  input  logic [3:0]  coef_addr,
  input  logic [19:0] coef_data,
  output logic        coef_err
);

  localparam int unsigned X_W   = 17;         // sample / result width
  localparam int unsigned C_W   = 20;         // coefficient width
  localparam int unsigned A_W   = 24;         // accumulator width (En20)
  localparam int unsigned P_W   = A_W + X_W;  // full product width (En36)
  localparam int unsigned W_W   = P_W + 1;    // headroom for round/add/compare
  localparam int unsigned K_W   = 4;          // coefficient index width
  localparam int unsigned CNT_W = 3;          // multiplier wait counter width

  localparam logic signed [W_W-1:0] ACC_MAX = W_W'(2 ** (A_W - 1) - 1);
  localparam logic signed [W_W-1:0] ACC_MIN = ~ACC_MAX;
  localparam logic signed [W_W-1:0] OUT_MAX = W_W'(2 ** (X_W - 1) - 1);
  localparam logic signed [W_W-1:0] OUT_MIN = ~OUT_MAX;

  typedef enum logic [2:0] {IDLE, INIT, MUL, ACC, OUT} state_t;

  state_t                state;
  logic signed [C_W-1:0] coef [NUM_COEF];
  logic signed [A_W-1:0] acc;
  logic signed [X_W-1:0] x_reg;
  logic signed [P_W-1:0] pipe [MUL_STAGES];
  logic [K_W-1:0]        k;
  logic [CNT_W-1:0]      cnt;
  logic                  err_q;

  logic signed [P_W-1:0] prod_c;
  logic signed [C_W-1:0] coef_sel_c;
  logic signed [A_W-1:0] coef_sh_c;
  logic signed [W_W-1:0] rnd_c;
  logic signed [W_W-1:0] sum_c;
  logic signed [W_W-1:0] out_c;
  logic signed [A_W-1:0] prod_sat_c;
  logic signed [A_W-1:0] acc_next_c;
  logic signed [X_W-1:0] out_sat_c;
  logic                  prod_ovf_c;
  logic                  sum_ovf_c;
  logic                  out_ovf_c;
  logic                  addr_ok_c;

  // Shared multiplier input: acc and x are stable for the whole MUL phase.
  assign prod_c    = P_W'(acc) * P_W'(x_reg);
  assign in_ready  = (state == IDLE) && clk_enable;
  assign coef_err  = err_q && clk_enable;
  assign addr_ok_c = (32'(coef_addr) < NUM_COEF);

  // Datapath: round/saturate product, add aligned coefficient, form output.
  always_comb begin
    coef_sel_c = (state == INIT) ? coef[NUM_COEF-1] : coef[k];
    // En18 -> En20 alignment after sign extension to the accumulator width
    coef_sh_c  = A_W'(coef_sel_c) <<< 2;

    // Round half toward +inf, En36 -> En20
    rnd_c      = (W_W'(pipe[MUL_STAGES-1]) + W_W'(32768)) >>> 16;
    prod_ovf_c = 1'b0;
    prod_sat_c = rnd_c[A_W-1:0];
    if (rnd_c > ACC_MAX) begin
      prod_sat_c = ACC_MAX[A_W-1:0];
      prod_ovf_c = 1'b1;
    end else if (rnd_c < ACC_MIN) begin
      prod_sat_c = ACC_MIN[A_W-1:0];
      prod_ovf_c = 1'b1;
    end

    sum_c      = W_W'(prod_sat_c) + W_W'(coef_sh_c);
    sum_ovf_c  = 1'b0;
    acc_next_c = sum_c[A_W-1:0];
    if (sum_c > ACC_MAX) begin
      acc_next_c = ACC_MAX[A_W-1:0];
      sum_ovf_c  = 1'b1;
    end else if (sum_c < ACC_MIN) begin
      acc_next_c = ACC_MIN[A_W-1:0];
      sum_ovf_c  = 1'b1;
    end

    // Result formed from the final accumulator value, En20 -> En16 rounded
    out_c     = (W_W'(acc_next_c) + W_W'(8)) >>> 4;
    out_ovf_c = 1'b0;
    out_sat_c = out_c[X_W-1:0];
    if (out_c > OUT_MAX) begin
      out_sat_c = OUT_MAX[X_W-1:0];
      out_ovf_c = 1'b1;
    end else if (out_c < OUT_MIN) begin
      out_sat_c = OUT_MIN[X_W-1:0];
      out_ovf_c = 1'b1;
    end
  end

  // Sequencer, coefficient file and multiplier pipeline.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      acc       <= '0;
      x_reg     <= '0;
      k         <= '0;
      cnt       <= '0;
      Out1      <= '0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < int'(NUM_COEF); i++) coef[i] <= '0;
      for (int i = 0; i < int'(MUL_STAGES); i++) pipe[i] <= '0;
    end else if (clk_enable) begin
      // Writes land only while idle so an evaluation never sees a torn set
      err_q <= 1'b0;
      if (coef_we) begin
        if (state == IDLE && addr_ok_c) coef[coef_addr] <= coef_data;
        else                            err_q <= 1'b1;
      end

      pipe[0] <= prod_c;
      for (int i = 1; i < int'(MUL_STAGES); i++) pipe[i] <= pipe[i-1];

      case (state)
        IDLE: begin
          if (in_valid) begin
            x_reg <= In1;
            state <= INIT;
          end
        end
        INIT: begin
          acc   <= coef_sh_c;
          k     <= K_W'(NUM_COEF - 2);
          ovf   <= 1'b0;
          cnt   <= '0;
          state <= MUL;
        end
        MUL: begin
          // Wait for the product to drain through the multiplier pipeline
          if (cnt == CNT_W'(MUL_STAGES - 1)) begin
            cnt   <= '0;
            state <= ACC;
          end else begin
            cnt <= cnt + CNT_W'(1);
          end
        end
        ACC: begin
          acc <= acc_next_c;
          if (k == '0) begin
            Out1      <= out_sat_c;
            ovf       <= ovf | prod_ovf_c | sum_ovf_c | out_ovf_c;
            out_valid <= 1'b1;
            state     <= OUT;
          end else begin
            ovf   <= ovf | prod_ovf_c | sum_ovf_c;
            k     <= k - K_W'(1);
            state <= MUL;
          end
        end
        OUT: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_poly_horner_sequencer.sv
// tb_poly_horner_sequencer
// Self-checking bench: directed and randomized evaluations compared against a
// plain-arithmetic Horner model with saturation, plus handshake/latency checks.
`timescale 1ns/1ps
module tb_poly_horner_sequencer;

  localparam int unsigned NUM_COEF   = 10;
  localparam int unsigned MUL_STAGES = 2;
  localparam int LAT    = 2 + (int'(NUM_COEF) - 1) * (int'(MUL_STAGES) + 1);
  localparam int BUDGET = 400;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        clk_enable = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [16:0] In1 = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [16:0] Out1;
  logic        ovf;
  logic        coef_we = 1'b0;
  logic [3:0]  coef_addr = '0;
  logic [19:0] coef_data = '0;
  logic        coef_err;

  logic [19:0] mcoef [NUM_COEF];
  int          n_checks = 0;
  int          n_errors = 0;

  poly_horner_sequencer #(.NUM_COEF(NUM_COEF), .MUL_STAGES(MUL_STAGES)) dut (
    .clk(clk), .reset(reset), .clk_enable(clk_enable),
    .in_valid(in_valid), .in_ready(in_ready), .In1(In1),
    .out_valid(out_valid), .out_ready(out_ready), .Out1(Out1), .ovf(ovf),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_err(coef_err)
  );

  always #5 clk = ~clk;

  // Reference: y = sum ck*x^k evaluated Horner-style on integers with
  // round-half-up product scaling and saturation at every stage.
  task automatic model_eval(input logic [16:0] x, output logic [16:0] y, output logic ov);
    longint a, r, xs, amax, amin;
    amax = 64'sd8388607;
    amin = -64'sd8388608;
    xs = longint'($signed(x));
    a  = longint'($signed(mcoef[NUM_COEF-1])) * 4;
    ov = 1'b0;
    for (int i = int'(NUM_COEF) - 2; i >= 0; i--) begin
      r = (a * xs + 32768) >>> 16;
      if (r > amax) begin r = amax; ov = 1'b1; end
      else if (r < amin) begin r = amin; ov = 1'b1; end
      a = r + longint'($signed(mcoef[i])) * 4;
      if (a > amax) begin a = amax; ov = 1'b1; end
      else if (a < amin) begin a = amin; ov = 1'b1; end
    end
    r = (a + 8) >>> 4;
    if (r > 65535) begin r = 65535; ov = 1'b1; end
    else if (r < -65536) begin r = -65536; ov = 1'b1; end
    y = r[16:0];
  endtask

  function automatic logic [19:0] rand_coef();
    logic [19:0] v;
    v = 20'($urandom);
    if ($urandom_range(1, 0) == 1) v = 20'($signed(v) >>> 3);
    return v;
  endfunction

  // Single write in IDLE; returns coef_err as seen in the following cycle.
  task automatic write_coef(input logic [3:0] addr, input logic [19:0] data, output logic err);
    coef_we = 1'b1; coef_addr = addr; coef_data = data;
    @(posedge clk); #1;
    coef_we = 1'b0;
    err = coef_err;
    if (32'(addr) < NUM_COEF) mcoef[addr] = data;
  endtask

  task automatic program_all();
    logic e;
    for (int i = 0; i < int'(NUM_COEF); i++) write_coef(4'(i), mcoef[i], e);
  endtask

  task automatic finish_out();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  // Offers x in the current cycle and waits for out_valid (out_ready low).
  // Optional coefficient write at cycle we_at (0 = accept cycle) and an
  // enable drop of drop_len cycles starting at drop_at.
  task automatic run_eval(input logic [16:0] x, input int we_at, input logic [3:0] waddr,
                          input logic [19:0] wdata, input int drop_at, input int drop_len,
                          output int lat, output logic [16:0] y, output logic ov, output int err_at);
    int  n;
    bit  done;
    lat = -1; err_at = -1; y = '0; ov = 1'b0; n = 0; done = 0;
    In1 = x; in_valid = 1'b1;
    if (we_at == 0) begin
      coef_we = 1'b1; coef_addr = waddr; coef_data = wdata;
      if (32'(waddr) < NUM_COEF) mcoef[waddr] = wdata;
    end
    while (!done && n < BUDGET) begin
      @(posedge clk); #1;
      n++;
      in_valid = 1'b0; coef_we = 1'b0;
      if (coef_err && err_at < 0) err_at = n;
      if (out_valid) begin
        lat = n; y = Out1; ov = ovf; done = 1;
      end else begin
        if (n == we_at) begin coef_we = 1'b1; coef_addr = waddr; coef_data = wdata; end
        clk_enable = !(n >= drop_at && n < drop_at + drop_len);
      end
    end
    clk_enable = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (Out1 !== 17'd0) begin n_errors++; $display("FAIL reset_out1: got %0d expected 0", Out1); end
    n_checks++; if ({ovf, coef_err} !== 2'b00) begin n_errors++; $display("FAIL reset_flags: got %b expected 00", {ovf, coef_err}); end
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = '0;
  endtask

  task automatic test_constant();
    int lat, ea; logic [16:0] y, ye; logic ov, oe;
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = '0;
    mcoef[0] = 20'd131072;
    program_all();
    run_eval(17'd12345, -1, 4'd0, 20'd0, -1, 0, lat, y, ov, ea);
    model_eval(17'd12345, ye, oe);
    n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL const_latency: got %0d expected %0d", lat, LAT); end
    n_checks++; if (y !== 17'd32768) begin n_errors++; $display("FAIL const_out1: got %0d expected 32768", $signed(y)); end
    n_checks++; if (ov !== 1'b0) begin n_errors++; $display("FAIL const_ovf: got %b expected 0", ov); end
    n_checks++; if (y !== ye) begin n_errors++; $display("FAIL const_model: got %0d expected %0d", $signed(y), $signed(ye)); end
    finish_out();
  endtask

  task automatic test_linear();
    int lat, ea; logic [16:0] y; logic ov;
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = '0;
    mcoef[1] = 20'd262144;
    program_all();
    run_eval(17'd16384, -1, 4'd0, 20'd0, -1, 0, lat, y, ov, ea);
    n_checks++; if (y !== 17'd16384) begin n_errors++; $display("FAIL linear_quarter: got %0d expected 16384", $signed(y)); end
    finish_out();
    run_eval(17'h10000, -1, 4'd0, 20'd0, -1, 0, lat, y, ov, ea);
    n_checks++; if (y !== 17'h10000) begin n_errors++; $display("FAIL linear_minus_one: got %0d expected -65536", $signed(y)); end
    n_checks++; if (ov !== 1'b0) begin n_errors++; $display("FAIL linear_ovf: got %b expected 0", ov); end
    finish_out();
  endtask

  task automatic test_reset_mid();
    int lat, ea, seen; logic [16:0] y, ye; logic ov, oe;
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = rand_coef();
    mcoef[0] = 20'd100000;
    program_all();
    In1 = 17'($urandom); in_valid = 1'b1;
    @(posedge clk); #1 in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk); #1 reset = 1'b0;
    n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL rstmid_in_ready: got %b expected 1", in_ready); end
    n_checks++; if (out_valid !== 1'b0) begin n_errors++; $display("FAIL rstmid_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (Out1 !== 17'd0) begin n_errors++; $display("FAIL rstmid_out1: got %0d expected 0", $signed(Out1)); end
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = '0;
    seen = 0;
    repeat (LAT + 10) begin @(posedge clk); #1 if (out_valid) seen++; end
    n_checks++; if (seen !== 0) begin n_errors++; $display("FAIL rstmid_no_result: got %0d valid cycles expected 0", seen); end
    run_eval(17'd40000, -1, 4'd0, 20'd0, -1, 0, lat, y, ov, ea);
    model_eval(17'd40000, ye, oe);
    n_checks++; if (y !== ye || y !== 17'd0) begin n_errors++; $display("FAIL rstmid_coef_cleared: got %0d expected 0", $signed(y)); end
    finish_out();
  endtask

  task automatic test_saturation();
    int lat, ea; logic [16:0] y; logic ov;
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = 20'd393216;
    program_all();
    run_eval(17'd65535, -1, 4'd0, 20'd0, -1, 0, lat, y, ov, ea);
    n_checks++; if (y !== 17'd65535) begin n_errors++; $display("FAIL sat_out1: got %0d expected 65535", $signed(y)); end
    n_checks++; if (ov !== 1'b1) begin n_errors++; $display("FAIL sat_ovf: got %b expected 1", ov); end
    finish_out();
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = '0;
    program_all();
    run_eval(17'd65535, -1, 4'd0, 20'd0, -1, 0, lat, y, ov, ea);
    n_checks++; if ({y, ov} !== 18'd0) begin n_errors++; $display("FAIL sat_cleared: got y=%0d ovf=%b expected y=0 ovf=0", $signed(y), ov); end
    finish_out();
  endtask

  task automatic test_coef_err();
    int lat, ea; logic [16:0] x, y, ye; logic ov, oe, e;
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = rand_coef();
    program_all();
    x = 17'($urandom);
    run_eval(x, 3, 4'd0, ~mcoef[0], -1, 0, lat, y, ov, ea);
    model_eval(x, ye, oe);
    n_checks++; if (ea !== 4) begin n_errors++; $display("FAIL busy_err_pulse: got cycle %0d expected 4", ea); end
    finish_out();
    x = 17'($urandom);
    run_eval(x, -1, 4'd0, 20'd0, -1, 0, lat, y, ov, ea);
    model_eval(x, ye, oe);
    n_checks++; if ({y, ov} !== {ye, oe}) begin n_errors++; $display("FAIL busy_write_ignored: got %0d/%b expected %0d/%b", $signed(y), ov, $signed(ye), oe); end
    finish_out();
    write_coef(4'd12, 20'h7ffff, e);
    n_checks++; if (e !== 1'b1) begin n_errors++; $display("FAIL badaddr_err: got %b expected 1", e); end
    @(posedge clk); #1;
    n_checks++; if (coef_err !== 1'b0) begin n_errors++; $display("FAIL badaddr_pulse_width: got %b expected 0", coef_err); end
    write_coef(4'(NUM_COEF - 1), rand_coef(), e);
    n_checks++; if (e !== 1'b0) begin n_errors++; $display("FAIL lastaddr_no_err: got %b expected 0", e); end
    x = 17'($urandom);
    run_eval(x, -1, 4'd0, 20'd0, -1, 0, lat, y, ov, ea);
    model_eval(x, ye, oe);
    n_checks++; if ({y, ov} !== {ye, oe}) begin n_errors++; $display("FAIL badaddr_no_change: got %0d/%b expected %0d/%b", $signed(y), ov, $signed(ye), oe); end
    finish_out();
  endtask

  task automatic test_backpressure();
    int lat, ea; logic [16:0] x, y, ye; logic ov, oe;
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = rand_coef();
    program_all();
    x = 17'($urandom);
    run_eval(x, -1, 4'd0, 20'd0, -1, 0, lat, y, ov, ea);
    model_eval(x, ye, oe);
    n_checks++; if ({y, ov} !== {ye, oe}) begin n_errors++; $display("FAIL bp_result: got %0d/%b expected %0d/%b", $signed(y), ov, $signed(ye), oe); end
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      n_checks++;
      if ({out_valid, in_ready, Out1, ovf} !== {1'b1, 1'b0, ye, oe}) begin
        n_errors++;
        $display("FAIL bp_hold_%0d: got v=%b r=%b y=%0d o=%b expected v=1 r=0 y=%0d o=%b",
                 c, out_valid, in_ready, $signed(Out1), ovf, $signed(ye), oe);
      end
    end
    in_valid = 1'b0;
    finish_out();
    n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_errors++; $display("FAIL bp_release: got v/r=%b expected 01", {out_valid, in_ready}); end
  endtask

  task automatic test_enable();
    int lat, ea; logic [16:0] x, y, ye; logic ov, oe;
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = rand_coef();
    program_all();
    x = 17'($urandom);
    run_eval(x, -1, 4'd0, 20'd0, 3, 3, lat, y, ov, ea);
    model_eval(x, ye, oe);
    n_checks++; if (lat !== LAT + 3) begin n_errors++; $display("FAIL en_latency: got %0d expected %0d", lat, LAT + 3); end
    n_checks++; if ({y, ov} !== {ye, oe}) begin n_errors++; $display("FAIL en_result: got %0d/%b expected %0d/%b", $signed(y), ov, $signed(ye), oe); end
    finish_out();
    clk_enable = 1'b0; #1;
    n_checks++; if (in_ready !== 1'b0) begin n_errors++; $display("FAIL en_in_ready: got %b expected 0", in_ready); end
    clk_enable = 1'b1; #1;
  endtask

  task automatic test_write_on_accept();
    int lat, ea; logic [16:0] x, y, ye; logic ov, oe;
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = rand_coef();
    program_all();
    x = 17'($urandom);
    run_eval(x, 0, 4'(NUM_COEF - 1), rand_coef(), -1, 0, lat, y, ov, ea);
    model_eval(x, ye, oe);
    n_checks++; if (ea !== -1) begin n_errors++; $display("FAIL accept_write_err: got cycle %0d expected none", ea); end
    n_checks++; if ({y, ov} !== {ye, oe}) begin n_errors++; $display("FAIL accept_write_used: got %0d/%b expected %0d/%b", $signed(y), ov, $signed(ye), oe); end
    finish_out();
  endtask

  task automatic test_back_to_back();
    int lat, ea; logic [16:0] x, y, ye; logic ov, oe;
    for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = rand_coef();
    program_all();
    for (int it = 0; it < 4; it++) begin
      n_checks++; if (in_ready !== 1'b1) begin n_errors++; $display("FAIL b2b_ready_%0d: got %b expected 1", it, in_ready); end
      x = 17'($urandom);
      run_eval(x, -1, 4'd0, 20'd0, -1, 0, lat, y, ov, ea);
      model_eval(x, ye, oe);
      n_checks++; if (lat !== LAT) begin n_errors++; $display("FAIL b2b_latency_%0d: got %0d expected %0d", it, lat, LAT); end
      n_checks++; if ({y, ov} !== {ye, oe}) begin n_errors++; $display("FAIL b2b_result_%0d: got %0d/%b expected %0d/%b", it, $signed(y), ov, $signed(ye), oe); end
      finish_out();
    end
  endtask

  task automatic test_random();
    int lat, ea; logic [16:0] x, y, ye; logic ov, oe;
    for (int it = 0; it < 10; it++) begin
      for (int i = 0; i < int'(NUM_COEF); i++) mcoef[i] = rand_coef();
      program_all();
      x = 17'($urandom);
      run_eval(x, -1, 4'd0, 20'd0, -1, 0, lat, y, ov, ea);
      model_eval(x, ye, oe);
      n_checks++; if ({y, ov} !== {ye, oe}) begin n_errors++; $display("FAIL rand_%0d: x=%0d got %0d/%b expected %0d/%b", it, $signed(x), $signed(y), ov, $signed(ye), oe); end
      finish_out();
    end
  endtask

  initial begin
    test_reset();
    test_constant();
    test_linear();
    test_reset_mid();
    test_saturation();
    test_coef_err();
    test_backpressure();
    test_enable();
    test_write_on_accept();
    test_back_to_back();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
